// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared constants for the unified byte-wide RAM port controller:
//   - read/write and enable/disable encodings
//   - funct3 and register widths
//   - FSM state and port-owner encodings
//   - funct3 -> byte-count mapping
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

  localparam logic READ_OP  = 1'b0;
  localparam logic WRITE_OP = 1'b1;
  localparam logic ENABLE   = 1'b1;
  localparam logic DISABLE  = 1'b0;

  localparam int FUNCT3_LEN = 3;
  localparam int REG_LEN    = 32;
  localparam int CNT_W      = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_MEM = 1'b1;

  // Access size in bytes from funct3[1:0]: 00=1, 01=2, 1x=4.
  function automatic logic [CNT_W-1:0] funct3_to_len(input logic [1:0] size_code);
    logic [CNT_W-1:0] len;
    case (size_code)
      2'b00:   len = 3'd1;
      2'b01:   len = 3'd2;
      default: len = 3'd4;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Sole owner of the byte-wide unified RAM port. Arbitrates between instruction
// fetch (IF) and load/store (MEM); MEM always wins a tie. Multi-byte accesses
// are sequenced one byte per cycle, little-endian, and completion is reported
// with a one-cycle ready pulse in the DONE state.
//
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (low freezes everything)
//   if_req_i/if_addr_i/if_flush_i     -> if_ready_o/if_inst_o
//   mem_wr_enable_i/mem_wr_i/mem_funct3_i/mem_addr_i/mem_data_i
//                                     -> load_store_ready_o/load_data_o
//   memctrl_off_o : 1 when no MEM access is outstanding
//   ram_din_i / ram_dout_o / ram_a_o / ram_wr_o : RAM side (sync-read RAM)
//
// Optional feature (macro MEMCTRL_IO_FULL_EN): adds io_buffer_full_i; write
// bytes at addresses >= IO_BASE wait while it is high, and every I/O byte
// write is followed by one idle cycle.
// -----------------------------------------------------------------------------
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = 32'h30000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_ready_o,
  output logic [31:0]       if_inst_o,
  input  logic              mem_wr_enable_i,
  input  logic              mem_wr_i,
  input  logic [2:0]        mem_funct3_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_data_i,
  output logic              load_store_ready_o,
  output logic [31:0]       load_data_o,
  output logic              memctrl_off_o,
`ifdef MEMCTRL_IO_FULL_EN
  input  logic              io_buffer_full_i,
`endif
  input  logic [7:0]        ram_din_i,
  output logic [7:0]        ram_dout_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_wr_o
);

  logic [1:0]         state_r, state_nxt_s;
  logic               owner_r, owner_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic [CNT_W-1:0]   len_r, len_nxt_s;
  logic [ADDR_W-1:0]  base_r, base_nxt_s;
  logic [REG_LEN-1:0] data_r, data_nxt_s;
  logic               gap_r, gap_nxt_s;
  logic               if_ready_r, if_ready_nxt_s;
  logic               ls_ready_r, ls_ready_nxt_s;
  logic [31:0]        if_inst_r, if_inst_nxt_s;
  logic [31:0]        load_data_r, load_data_nxt_s;
  logic [7:0]         ram_dout_r, ram_dout_nxt_s;
  logic [ADDR_W-1:0]  ram_a_r, ram_a_nxt_s;
  logic               ram_wr_r, ram_wr_nxt_s;

  logic               io_full_s;
  logic               io_gap_en_s;
  logic               mem_req_s;
  logic               if_req_ok_s;
  logic               flush_if_s;
  logic [ADDR_W-1:0]  byte_addr_s;
  logic [7:0]         wr_byte_s;
  logic [1:0]         cap_idx_s;
  logic [REG_LEN-1:0] asm_s;
  logic               acc_io_s;
  logic               byte_io_s;
  logic               unused_s;

  // Without the I/O back-pressure feature the blocking terms are tied off and
  // the related logic folds away.
`ifdef MEMCTRL_IO_FULL_EN
  assign io_full_s   = io_buffer_full_i;
  assign io_gap_en_s = 1'b1;
`else
  assign io_full_s   = 1'b0;
  assign io_gap_en_s = 1'b0;
`endif

  assign unused_s    = mem_funct3_i[2];
  assign mem_req_s   = (mem_wr_enable_i == ENABLE);
  assign if_req_ok_s = if_req_i & ~if_flush_i;
  assign flush_if_s  = if_flush_i & (owner_r == OWNER_IF);
  // cnt_r doubles as the index of the next byte to issue.
  assign byte_addr_s = base_r + ADDR_W'(cnt_r);
  assign wr_byte_s   = data_r[{cnt_r[1:0], 3'b000} +: 8];
  // Read data lags the issued address by two edges.
  assign cap_idx_s   = 2'(cnt_r - 3'd2);
  assign acc_io_s    = (mem_addr_i >= IO_BASE);
  assign byte_io_s   = (byte_addr_s >= IO_BASE);

  assign if_ready_o         = if_ready_r;
  assign if_inst_o          = if_inst_r;
  assign load_store_ready_o = ls_ready_r;
  assign load_data_o        = load_data_r;
  assign ram_dout_o         = ram_dout_r;
  assign ram_a_o            = ram_a_r;
  // A stalled write strobe is withheld so the byte is re-issued on resume.
  assign ram_wr_o           = ram_wr_r & rdy_in;
  assign memctrl_off_o      = ~mem_wr_enable_i | ((state_r == ST_DONE) & (owner_r == OWNER_MEM));

  // Merge the incoming RAM byte into the assembly word.
  always_comb begin
    asm_s = data_r;
    asm_s[{cap_idx_s, 3'b000} +: 8] = ram_din_i;
  end

  // State and registered outputs; rdy_in low freezes everything.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r     <= ST_IDLE;
      owner_r     <= OWNER_IF;
      cnt_r       <= 3'd0;
      len_r       <= 3'd0;
      base_r      <= {ADDR_W{1'b0}};
      data_r      <= 32'd0;
      gap_r       <= 1'b0;
      if_ready_r  <= 1'b0;
      ls_ready_r  <= 1'b0;
      if_inst_r   <= 32'd0;
      load_data_r <= 32'd0;
      ram_dout_r  <= 8'd0;
      ram_a_r     <= {ADDR_W{1'b0}};
      ram_wr_r    <= 1'b0;
    end else if (rdy_in) begin
      state_r     <= state_nxt_s;
      owner_r     <= owner_nxt_s;
      cnt_r       <= cnt_nxt_s;
      len_r       <= len_nxt_s;
      base_r      <= base_nxt_s;
      data_r      <= data_nxt_s;
      gap_r       <= gap_nxt_s;
      if_ready_r  <= if_ready_nxt_s;
      ls_ready_r  <= ls_ready_nxt_s;
      if_inst_r   <= if_inst_nxt_s;
      load_data_r <= load_data_nxt_s;
      ram_dout_r  <= ram_dout_nxt_s;
      ram_a_r     <= ram_a_nxt_s;
      ram_wr_r    <= ram_wr_nxt_s;
    end
  end

  // Next-state logic: arbitration, byte sequencing end points, flush abort.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_req_s) begin
          state_nxt_s = (mem_wr_i == WRITE_OP) ? ST_WRITE : ST_READ;
        end else if (if_req_ok_s) begin
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (flush_if_s) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == len_r + 3'd1) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      ST_WRITE: begin
        if (!gap_r && (cnt_r == len_r)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the datapath and the registered outputs.
  always_comb begin
    owner_nxt_s     = owner_r;
    cnt_nxt_s       = cnt_r;
    len_nxt_s       = len_r;
    base_nxt_s      = base_r;
    data_nxt_s      = data_r;
    gap_nxt_s       = gap_r;
    if_ready_nxt_s  = 1'b0;
    ls_ready_nxt_s  = 1'b0;
    if_inst_nxt_s   = if_inst_r;
    load_data_nxt_s = load_data_r;
    ram_dout_nxt_s  = ram_dout_r;
    ram_a_nxt_s     = ram_a_r;
    ram_wr_nxt_s    = DISABLE;
    case (state_r)
      ST_IDLE: begin
        if (mem_req_s) begin
          owner_nxt_s = OWNER_MEM;
          len_nxt_s   = funct3_to_len(mem_funct3_i[1:0]);
          base_nxt_s  = mem_addr_i;
          ram_a_nxt_s = mem_addr_i;
          gap_nxt_s   = 1'b0;
          if (mem_wr_i == WRITE_OP) begin
            data_nxt_s = mem_data_i;
            if (io_full_s && acc_io_s) begin
              // Byte 0 is retried from WRITE once the I/O buffer drains.
              cnt_nxt_s = 3'd0;
            end else begin
              cnt_nxt_s      = 3'd1;
              ram_dout_nxt_s = mem_data_i[7:0];
              ram_wr_nxt_s   = ENABLE;
              gap_nxt_s      = io_gap_en_s & acc_io_s;
            end
          end else begin
            data_nxt_s = 32'd0;
            cnt_nxt_s  = 3'd1;
          end
        end else if (if_req_ok_s) begin
          owner_nxt_s = OWNER_IF;
          len_nxt_s   = 3'd4;
          base_nxt_s  = if_addr_i;
          ram_a_nxt_s = if_addr_i;
          data_nxt_s  = 32'd0;
          cnt_nxt_s   = 3'd1;
          gap_nxt_s   = 1'b0;
        end else begin
          cnt_nxt_s = 3'd0;
        end
      end
      ST_READ: begin
        if (flush_if_s) begin
          cnt_nxt_s = 3'd0;
        end else begin
          cnt_nxt_s = cnt_r + 3'd1;
          if (cnt_r < len_r) begin
            ram_a_nxt_s = byte_addr_s;
          end else begin
            ram_a_nxt_s = ram_a_r;
          end
          if (cnt_r >= 3'd2) begin
            data_nxt_s = asm_s;
          end else begin
            data_nxt_s = data_r;
          end
          if (cnt_r == len_r + 3'd1) begin
            cnt_nxt_s = 3'd0;
            if (owner_r == OWNER_MEM) begin
              ls_ready_nxt_s  = 1'b1;
              load_data_nxt_s = asm_s;
            end else begin
              if_ready_nxt_s = 1'b1;
              if_inst_nxt_s  = asm_s;
            end
          end else begin
            ls_ready_nxt_s = 1'b0;
          end
        end
      end
      ST_WRITE: begin
        if (gap_r) begin
          gap_nxt_s = 1'b0;
        end else if (cnt_r < len_r) begin
          if (io_full_s && byte_io_s) begin
            cnt_nxt_s = cnt_r;
          end else begin
            ram_a_nxt_s    = byte_addr_s;
            ram_dout_nxt_s = wr_byte_s;
            ram_wr_nxt_s   = ENABLE;
            cnt_nxt_s      = cnt_r + 3'd1;
            gap_nxt_s      = io_gap_en_s & byte_io_s;
          end
        end else begin
          ls_ready_nxt_s = 1'b1;
          cnt_nxt_s      = 3'd0;
        end
      end
      ST_DONE:  cnt_nxt_s = 3'd0;
      default:  cnt_nxt_s = 3'd0;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Directed bench for mem_ctrl with a byte-wide synchronous RAM model and a
// scoreboard of expected ready pulses (owner + data).
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic        if_ready_o;
  logic [31:0] if_inst_o;
  logic        mem_wr_enable_i;
  logic        mem_wr_i;
  logic [2:0]  mem_funct3_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic        load_store_ready_o;
  logic [31:0] load_data_o;
  logic        memctrl_off_o;
  logic [7:0]  ram_din_i;
  logic [7:0]  ram_dout_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o;

  mem_ctrl #(.ADDR_W(32), .IO_BASE(32'h30000)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .rdy_in             (rdy_in),
    .if_req_i           (if_req_i),
    .if_addr_i          (if_addr_i),
    .if_flush_i         (if_flush_i),
    .if_ready_o         (if_ready_o),
    .if_inst_o          (if_inst_o),
    .mem_wr_enable_i    (mem_wr_enable_i),
    .mem_wr_i           (mem_wr_i),
    .mem_funct3_i       (mem_funct3_i),
    .mem_addr_i         (mem_addr_i),
    .mem_data_i         (mem_data_i),
    .load_store_ready_o (load_store_ready_o),
    .load_data_o        (load_data_o),
    .memctrl_off_o      (memctrl_off_o),
`ifdef MEMCTRL_IO_FULL_EN
    .io_buffer_full_i   (1'b0),
`endif
    .ram_din_i          (ram_din_i),
    .ram_dout_o         (ram_dout_o),
    .ram_a_o            (ram_a_o),
    .ram_wr_o           (ram_wr_o)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Synchronous RAM model, frozen while rdy_in is low.
  logic [7:0] ram_mem [0:4095];
  int         wr_cnt  [0:4095];

  always @(posedge clk_in) begin
    if (rdy_in) begin
      ram_din_i <= ram_mem[ram_a_o[11:0]];
      if (ram_wr_o) begin
        ram_mem[ram_a_o[11:0]] <= ram_dout_o;
        wr_cnt[ram_a_o[11:0]]  <= wr_cnt[ram_a_o[11:0]] + 1;
      end
    end
  end

  typedef struct packed {
    logic        is_mem;
    logic        chk_data;
    logic [31:0] data;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic is_mem, input logic chk, input logic [31:0] d);
    sb_q.push_back({is_mem, chk, d});
  endtask

  task automatic sb_compare(input string tag);
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_unexpected_pulse"}, {30'd0, load_store_ready_o, if_ready_o}, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_owner"}, {30'd0, load_store_ready_o, if_ready_o}, e.is_mem ? 32'd2 : 32'd1);
      if (e.chk_data) check({tag, "_data"}, e.is_mem ? load_data_o : if_inst_o, e.data);
    end
  endtask

  // Advance to the next falling edge and check ready-pulse presence.
  task automatic step(input string tag, input logic exp_pulse);
    @(negedge clk_in);
    check({tag, "_pulse"}, {31'd0, if_ready_o | load_store_ready_o}, {31'd0, exp_pulse});
    if (if_ready_o | load_store_ready_o) sb_compare(tag);
  endtask

  task automatic drive_mem(input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
    mem_wr_enable_i = 1'b1;
    mem_wr_i        = wr;
    mem_funct3_i    = f3;
    mem_addr_i      = a;
    mem_data_i      = d;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i] = 8'h00;
      wr_cnt[i]  = 0;
    end
    ram_mem[12'h100] = 8'h13; ram_mem[12'h101] = 8'h05;
    ram_mem[12'h102] = 8'h00; ram_mem[12'h103] = 8'h00;
    ram_mem[12'h200] = 8'hAA; ram_mem[12'h201] = 8'hBB;
    ram_mem[12'h202] = 8'hCC; ram_mem[12'h203] = 8'hDD;
    ram_mem[12'h010] = 8'h80;

    rst_in = 1'b1; rdy_in = 1'b1;
    if_req_i = 1'b0; if_addr_i = 32'd0; if_flush_i = 1'b0;
    mem_wr_enable_i = 1'b0; mem_wr_i = 1'b0; mem_funct3_i = 3'd0;
    mem_addr_i = 32'd0; mem_data_i = 32'd0;

    // Reset state
    @(negedge clk_in); @(negedge clk_in);
    check("rst_ready", {30'd0, if_ready_o, load_store_ready_o}, 32'd0);
    check("rst_ram_side", {23'd0, ram_wr_o, ram_dout_o}, 32'd0);
    check("rst_ram_a", ram_a_o, 32'd0);
    check("rst_data", if_inst_o | load_data_o, 32'd0);
    check("rst_off_idle", {31'd0, memctrl_off_o}, 32'd1);
    rst_in = 1'b0;
    step("post_rst", 1'b0);

    // Fetch 0x100: address walk, ready 5 cycles after accept
    if_req_i = 1'b1; if_addr_i = 32'h100;
    push_exp(1'b0, 1'b1, 32'h00000513);
    for (int k = 0; k <= 5; k++) begin
      step("fetch", k == 5);
      if (k < 4) check("fetch_addr", ram_a_o, 32'h100 + k);
      check("fetch_wr", {31'd0, ram_wr_o}, 32'd0);
    end
    if_req_i = 1'b0;
    step("gap1", 1'b0);

    // Simultaneous fetch + LW 0x200: MEM first, fetch afterwards
    if_req_i = 1'b1; if_addr_i = 32'h100;
    drive_mem(1'b0, 3'b010, 32'h200, 32'd0);
    push_exp(1'b1, 1'b1, 32'hDDCCBBAA);
    push_exp(1'b0, 1'b1, 32'h00000513);
    #1 check("lw_off_req", {31'd0, memctrl_off_o}, 32'd0);
    for (int k = 0; k <= 5; k++) begin
      step("lw", k == 5);
      if (k == 0) check("lw_addr0", ram_a_o, 32'h200);
      check("lw_off", {31'd0, memctrl_off_o}, (k == 5) ? 32'd1 : 32'd0);
    end
    mem_wr_enable_i = 1'b0;
    step("lw_done_exit", 1'b0);
    for (int j = 0; j <= 5; j++) begin
      step("fetch2", j == 5);
      if (j == 0) check("fetch2_addr0", ram_a_o, 32'h100);
    end
    if_req_i = 1'b0;
    step("gap2", 1'b0);

    // SH 0x1234ABCD to 0x40
    drive_mem(1'b1, 3'b001, 32'h40, 32'h1234ABCD);
    push_exp(1'b1, 1'b0, 32'd0);
    step("sh0", 1'b0);
    check("sh0_bus", {ram_a_o[15:0], 7'd0, ram_wr_o, ram_dout_o}, {16'h0040, 7'd0, 1'b1, 8'hCD});
    step("sh1", 1'b0);
    check("sh1_bus", {ram_a_o[15:0], 7'd0, ram_wr_o, ram_dout_o}, {16'h0041, 7'd0, 1'b1, 8'hAB});
    step("sh_done", 1'b1);
    check("sh_wr_off", {31'd0, ram_wr_o}, 32'd0);
    mem_wr_enable_i = 1'b0;
    check("sh_mem", {16'd0, ram_mem[12'h041], ram_mem[12'h040]}, 32'h0000ABCD);
    check("sh_once", {wr_cnt[12'h040][7:0], wr_cnt[12'h041][7:0], wr_cnt[12'h042][7:0]}, 32'h00010100);
    step("gap3", 1'b0);

    // Flush on the 3rd fetch cycle, pending LB 0x10 served next
    if_req_i = 1'b1; if_addr_i = 32'h100;
    step("fl0", 1'b0);
    drive_mem(1'b0, 3'b000, 32'h10, 32'd0);
    push_exp(1'b1, 1'b1, 32'h00000080);
    step("fl1", 1'b0);
    step("fl2", 1'b0);
    if_flush_i = 1'b1; if_req_i = 1'b0;
    step("fl3", 1'b0);
    if_flush_i = 1'b0;
    check("fl_off", {31'd0, memctrl_off_o}, 32'd0);
    step("lb0", 1'b0);
    check("lb_addr", ram_a_o, 32'h10);
    step("lb1", 1'b0);
    step("lb2", 1'b1);
    mem_wr_enable_i = 1'b0;
    step("gap4", 1'b0);

    // LH 0x200: 3-cycle latency, upper half zero
    drive_mem(1'b0, 3'b101, 32'h200, 32'd0);
    push_exp(1'b1, 1'b1, 32'h0000BBAA);
    for (int k = 0; k <= 3; k++) step("lh", k == 3);
    mem_wr_enable_i = 1'b0;
    step("gap5", 1'b0);

    // SW 0xA1B2C3D4 to 0x80 with rdy_in low for 3 cycles mid-access
    drive_mem(1'b1, 3'b010, 32'h80, 32'hA1B2C3D4);
    push_exp(1'b1, 1'b0, 32'd0);
    step("sw0", 1'b0);
    step("sw1", 1'b0);
    check("sw1_addr", ram_a_o, 32'h81);
    rdy_in = 1'b0;
    #1 check("stall_wr_now", {31'd0, ram_wr_o}, 32'd0);
    for (int s = 0; s < 3; s++) begin
      step("stall", 1'b0);
      check("stall_wr", {31'd0, ram_wr_o}, 32'd0);
    end
    rdy_in = 1'b1;
    #1 check("resume_reissue", {ram_a_o[23:0], 7'd0, ram_wr_o}, {24'h000081, 7'd0, 1'b1});
    step("sw2", 1'b0);
    check("sw2_addr", ram_a_o, 32'h82);
    step("sw3", 1'b0);
    check("sw3_addr", ram_a_o, 32'h83);
    step("sw_done", 1'b1);
    mem_wr_enable_i = 1'b0;
    check("sw_mem", {ram_mem[12'h083], ram_mem[12'h082], ram_mem[12'h081], ram_mem[12'h080]}, 32'hA1B2C3D4);
    check("sw_once", {wr_cnt[12'h080][7:0], wr_cnt[12'h081][7:0], wr_cnt[12'h082][7:0], wr_cnt[12'h083][7:0]}, 32'h01010101);
    step("gap6", 1'b0);

    // Reset during the 2nd byte of an SW
    drive_mem(1'b1, 3'b010, 32'hC0, 32'h55667788);
    step("rsw0", 1'b0);
    step("rsw1", 1'b0);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("mrst_ready", {30'd0, if_ready_o, load_store_ready_o}, 32'd0);
    check("mrst_ram_side", {23'd0, ram_wr_o, ram_dout_o}, 32'd0);
    check("mrst_ram_a", ram_a_o, 32'd0);
    check("mrst_data", if_inst_o | load_data_o, 32'd0);
    check("mrst_off", {31'd0, memctrl_off_o}, 32'd0);
    rst_in = 1'b0;
    mem_wr_enable_i = 1'b0;
    for (int s = 0; s < 6; s++) begin
      step("after_rst", 1'b0);
      check("after_rst_wr", {31'd0, ram_wr_o}, 32'd0);
    end
    check("rst_writes", {wr_cnt[12'h0C0][7:0], wr_cnt[12'h0C1][7:0], wr_cnt[12'h0C2][7:0], wr_cnt[12'h0C3][7:0]}, 32'h01010000);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
